// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow sequencer: stage enables, flushes and bubbles for load-use,
// taken-branch, data-memory wait and syscall drain-to-halt, plus perf counters.
//
// state   | meaning
// --------+----------------------------------------------------------
// RUN     | normal issue; branch/load-use/syscall decisions applied
// MEMWAIT | frozen on a data-memory access, MEM/WB fed bubbles
// DRAIN   | syscall seen, no new fetch, older instructions retire
// HALT    | pipeline stopped until reset
module pipe_flow_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_syscall,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_write_reg,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             halted,
    output logic             mem_error,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    localparam int DW = $clog2(DRAIN_CYCLES + 2);
    localparam int WW = $clog2(MEM_TIMEOUT + 2);

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] drain_q, drain_d, drain_inc;
    logic [WW-1:0] wait_q, wait_d, wait_inc;
    logic          err_set;
    logic          memstall, load_use, freeze;
    logic          pc_c, ifid_c, idex_c, exmem_c, memwb_c;
    logic          ifid_fl_c, idex_fl_c, bubble_c;

    assign memstall = mem_req && !mem_ready;
    assign load_use = ex_memRead && (ex_write_reg != 5'd0) &&
                      ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        wait_d    = wait_q;
        drain_inc = drain_q + DW'(1);
        wait_inc  = wait_q + WW'(1);
        err_set   = 1'b0;
        freeze    = 1'b0;
        pc_c      = 1'b0;
        ifid_c    = 1'b0;
        idex_c    = 1'b0;
        exmem_c   = 1'b0;
        memwb_c   = 1'b0;
        ifid_fl_c = 1'b0;
        idex_fl_c = 1'b0;
        bubble_c  = 1'b0;
        case (state_q)
            ST_RUN, ST_MEMWAIT: begin
                // Once waiting, only mem_ready releases the freeze
                freeze = (state_q == ST_RUN) ? memstall : !mem_ready;
                if (freeze) begin
                    memwb_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d = ST_MEMWAIT;
                        wait_d  = WW'(1);
                    end else if (wait_inc >= WW'(MEM_TIMEOUT)) begin
                        state_d = ST_HALT;
                        err_set = 1'b1;
                    end else begin
                        wait_d = wait_inc;
                    end
                end else begin
                    state_d = ST_RUN;
                    {pc_c, ifid_c, idex_c, exmem_c, memwb_c} = 5'b11111;
                    if (ex_branch_taken) begin
                        ifid_fl_c = 1'b1;
                        idex_fl_c = 1'b1;
                    end else if (load_use) begin
                        pc_c      = 1'b0;
                        ifid_c    = 1'b0;
                        idex_fl_c = 1'b1;
                    end else if (id_syscall) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (memstall) begin
                    memwb_c  = 1'b1;
                    bubble_c = 1'b1;
                end else begin
                    {ifid_c, idex_c, exmem_c, memwb_c} = 4'b1111;
                    ifid_fl_c = 1'b1;
                    if (drain_inc >= DW'(DRAIN_CYCLES)) state_d = ST_HALT;
                    else drain_d = drain_inc;
                end
            end
            default: ;
        endcase
    end

    assign pc_en        = pc_c      & ~reset;
    assign ifid_en      = ifid_c    & ~reset;
    assign idex_en      = idex_c    & ~reset;
    assign exmem_en     = exmem_c   & ~reset;
    assign memwb_en     = memwb_c   & ~reset;
    assign ifid_flush   = ifid_fl_c & ~reset;
    assign idex_flush   = idex_fl_c & ~reset;
    assign memwb_bubble = bubble_c  & ~reset;
    assign halted       = (state_q == ST_HALT);
    assign state        = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            drain_q     <= '0;
            wait_q      <= '0;
            mem_error   <= 1'b0;
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            wait_q    <= wait_d;
            mem_error <= mem_error | err_set;
            if ((state_q != ST_HALT) && (cycle_count != '1))
                cycle_count <= cycle_count + CNT_W'(1);
            if (((state_q == ST_RUN) || (state_q == ST_MEMWAIT)) && !pc_c && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: fixed vector table, hand-built corner sequences
// and randomized traffic checked against a cycle-level behavioural model.
module tb_pipe_flow_ctrl;

    localparam int CNT_W   = 8;
    localparam int DRAIN   = 3;
    localparam int TIMEOUT = 5;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;
    logic [4:0] id_rs, id_rt, ex_write_reg;
    logic id_uses_rt, id_syscall, ex_memRead, ex_branch_taken, mem_req, mem_ready;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble;
    logic halted, mem_error;
    logic [1:0] state;
    logic [CNT_W-1:0] cycle_count, stall_count;
    logic [7:0] ctrl;

    int tests = 0;
    int fails = 0;

    // Model: mode uses the port encoding of the state output
    int m_mode, m_wait, m_drained, m_cyc, m_stall;
    bit m_err;

    pipe_flow_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_syscall(id_syscall),
        .ex_memRead(ex_memRead), .ex_write_reg(ex_write_reg), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .halted(halted), .mem_error(mem_error),
        .state(state), .cycle_count(cycle_count), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble};

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt, sys, memrd;
        logic [4:0] wr;
        logic       br, req, rdy;
        logic [7:0] exp_ctrl;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_in();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_syscall = 0; ex_memRead = 0;
        ex_write_reg = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    function automatic logic [7:0] model_ctrl();
        bit hazard, mstall, frozen;
        mstall = mem_req && !mem_ready;
        hazard = ex_memRead && ex_write_reg != 0 &&
                 (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt));
        if (m_mode == 3) return 8'h00;
        if (m_mode == 2) return mstall ? 8'h09 : 8'h7C;
        frozen = (m_mode == 1) ? !mem_ready : mstall;
        if (frozen) return 8'h09;
        if (ex_branch_taken) return 8'hFE;
        if (hazard) return 8'h3A;
        return 8'hF8;
    endfunction

    task automatic model_tick(input logic [7:0] c);
        bit mstall, normal;
        mstall = mem_req && !mem_ready;
        // an accepted syscall is one that was neither squashed nor stalled
        normal = (c == 8'hF8) && id_syscall;
        if (m_mode != 3 && m_cyc < CMAX) m_cyc++;
        if (m_mode <= 1 && !c[7] && m_stall < CMAX) m_stall++;
        case (m_mode)
            0: if (mstall) begin m_mode = 1; m_wait = 1; end
               else if (normal) begin m_mode = 2; m_drained = 0; end
            1: if (!mem_ready) begin
                   m_wait++;
                   if (m_wait >= TIMEOUT) begin m_mode = 3; m_err = 1; end
               end else m_mode = normal ? 2 : 0;
            2: if (!mstall) begin
                   m_drained++;
                   if (m_drained == DRAIN) m_mode = 3;
               end
            default: ;
        endcase
    endtask

    task automatic cycle();
        logic [7:0] ec;
        #1;
        ec = model_ctrl();
        chk("ctrl", ctrl, ec);
        chk("state", state, m_mode);
        chk("halted", halted, m_mode == 3);
        chk("mem_error", mem_error, m_err);
        chk("cycle_count", cycle_count, m_cyc);
        chk("stall_count", stall_count, m_stall);
        @(posedge clock);
        model_tick(ec);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_ctrl", ctrl, 0);
        chk("rst_state", state, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mem_error", mem_error, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_stall_count", stall_count, 0);
        m_mode = 0; m_wait = 0; m_drained = 0; m_cyc = 0; m_stall = 0; m_err = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        //            rs  rt  urt sys mrd wr  br  req rdy  ctrl   next
        vecs[0]  = '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 8'hF8, 2'd0};
        vecs[1]  = '{5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 8'h3A, 2'd0};
        vecs[2]  = '{5'd4, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 8'h3A, 2'd0};
        vecs[3]  = '{5'd4, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 8'hF8, 2'd0};
        vecs[4]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'hF8, 2'd0};
        vecs[5]  = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 8'hF8, 2'd0};
        vecs[6]  = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 8'hFE, 2'd0};
        vecs[7]  = '{5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h09, 2'd1};
        vecs[8]  = '{5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'hF8, 2'd2};
        vecs[9]  = '{5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 8'h3A, 2'd0};
        vecs[10] = '{5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'hFE, 2'd0};
        vecs[11] = '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 8'hF8, 2'd0};
        vecs[12] = '{5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h09, 2'd1};

        clr_in();
        reset = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            do_reset();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
            id_syscall = vecs[i].sys; ex_memRead = vecs[i].memrd; ex_write_reg = vecs[i].wr;
            ex_branch_taken = vecs[i].br; mem_req = vecs[i].req; mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].exp_ctrl);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_next", i), state, vecs[i].exp_state);
            @(negedge clock);
            clr_in();
        end

        // single load-use stall
        do_reset();
        ex_memRead = 1; ex_write_reg = 8; id_rs = 8;
        cycle();
        clr_in();
        cycle();
        chk("loaduse_stalls", stall_count, 1);

        // four-cycle memory wait then release
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (4) cycle();
        mem_ready = 1;
        cycle();
        clr_in();
        chk("memwait_state", state, 0);
        chk("memwait_stalls", stall_count, 4);
        cycle();

        // memory timeout halts with error, counter frozen
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (8) cycle();
        chk("timeout_halted", halted, 1);
        chk("timeout_err", mem_error, 1);
        chk("timeout_cycles", cycle_count, 5);
        clr_in();

        // syscall drain with one mid-drain memory stall
        do_reset();
        id_syscall = 1;
        cycle();
        id_syscall = 0;
        cycle();
        mem_req = 1;
        cycle();
        mem_req = 0;
        cycle();
        cycle();
        chk("drain_halt", state, 3);
        chk("drain_halted", halted, 1);
        chk("drain_cycles", cycle_count, 5);
        repeat (2) cycle();

        // reset mid-drain returns to RUN immediately
        do_reset();
        id_syscall = 1;
        cycle();
        id_syscall = 0;
        cycle();
        chk("middrain_state", state, 2);
        do_reset();

        // counter saturation
        clr_in();
        repeat (CMAX + 10) cycle();
        chk("cycle_sat", cycle_count, CMAX);
        do_reset();
        ex_memRead = 1; ex_write_reg = 3; id_rs = 3;
        repeat (CMAX + 10) cycle();
        chk("stall_sat", stall_count, CMAX);
        clr_in();

        // randomized traffic
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                id_rs = 5'($urandom_range(0, 3));
                id_rt = 5'($urandom_range(0, 3));
                id_uses_rt = 1'($urandom_range(0, 1));
                id_syscall = ($urandom_range(0, 19) == 0);
                ex_memRead = 1'($urandom_range(0, 1));
                ex_write_reg = 5'($urandom_range(0, 3));
                ex_branch_taken = ($urandom_range(0, 5) == 0);
                mem_req = ($urandom_range(0, 2) == 0);
                mem_ready = 1'($urandom_range(0, 1));
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage enable, flush and bubble controls for:
  - load-use hazards
  - taken branches resolved in EX
  - multi-cycle data-memory waits
  - orderly syscall drain-and-halt, replacing in-register termination
- Also keeps cycle and stall performance counters.

Parameters:
- CNT_W, 32, width of the performance counters.
- DRAIN_CYCLES, 3, number of advancing cycles after a syscall in ID before halting.
- MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before the error halt.

Ports:
- clock  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- id_syscall  in  1  ID instruction is a syscall.
- ex_memRead  in  1  EX instruction is a load.
- ex_write_reg  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  load enables.
- ifid_flush, idex_flush  out  1 each  load a NOP/zero control word instead of the input.
- memwb_bubble  out  1  MEM/WB loads a zero control word (no register write).
- halted  out  1  pipeline is stopped.
- mem_error  out  1  sticky memory-timeout flag.
- state  out  2  encoding: RUN=0, MEMWAIT=1, DRAIN=2, HALT=3.
- cycle_count  out  CNT_W  number of non-HALT cycles.
- stall_count  out  CNT_W  number of cycles with pc_en=0 in RUN or MEMWAIT.

Behaviour:
- Reset (async, immediate):
  - state=RUN; counters=0; drain and wait counters=0; halted=0; mem_error=0.
  - All enable, flush and bubble outputs are 0 while reset is high.
- Control outputs are combinational from state and inputs. State and counters are registered.
- memstall = mem_req && !mem_ready. It has the highest priority in RUN and DRAIN:
  - pc_en, ifid_en, idex_en and exmem_en are 0.
  - memwb_en=1 and memwb_bubble=1, so writeback never repeats.
  - No flush is asserted. Branch, load-use and syscall are not acted on; they are re-evaluated after release.
- RUN with no memstall, evaluated in priority order:
  - ex_branch_taken: all enables 1; ifid_flush=1; idex_flush=1. A load-use or syscall in ID is squashed.
  - Load-use: ex_memRead && ex_write_reg!=0 && (ex_write_reg==id_rs || (id_uses_rt && ex_write_reg==id_rt)).
    - Action: pc_en=0, ifid_en=0, idex_flush=1; other enables 1.
    - Exactly 1 stall cycle per hazard.
  - id_syscall: normal advance this cycle; next state=DRAIN; drain counter=0.
  - Otherwise: all enables 1, no flush.
- RUN with memstall: next state=MEMWAIT; wait counter=1.
- MEMWAIT:
  - While !mem_ready: same outputs as memstall; wait counter increments.
  - Timeout: when the wait counter reaches MEM_TIMEOUT, mem_error<=1 and next state=HALT.
  - mem_ready=1: apply the RUN decision logic combinationally this cycle; next state=RUN (or DRAIN if a syscall is accepted).
- DRAIN:
  - Outputs: pc_en=0, ifid_en=1, ifid_flush=1 (no new instructions); idex_en, exmem_en and memwb_en are 1.
  - Branch and load-use are ignored.
  - The drain counter increments only on non-memstall cycles. When it reaches DRAIN_CYCLES, next state=HALT.
  - A memstall in DRAIN freezes as above; the state stays DRAIN.
- HALT:
  - All enables 0; halted=1.
  - Exit only via reset.
- Counters:
  - cycle_count increments in every state except HALT.
  - stall_count increments when pc_en=0 in RUN or MEMWAIT.
  - Both saturate at all-ones; no wrap.
- Simultaneous events:
  - memstall beats branch.
  - Branch beats load-use and syscall.
  - Load-use beats syscall: the syscall waits one cycle in ID.
- ex_write_reg==0 never causes a stall.

Test Plan:
- Load-use: ex_memRead=1, ex_write_reg=8, id_rs=8 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_count=1.
- Load-use disambiguation:
  - ex_write_reg=0, id_rs=0 → no stall.
  - id_uses_rt=0 with id_rt matching → no stall.
- Branch plus load-use in the same cycle → ifid_flush=1, idex_flush=1, pc_en=1, no stall.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 → state=MEMWAIT for 4 cycles, memwb_bubble=1 each cycle, stall_count=4, then RUN.
- Timeout: MEM_TIMEOUT=5, mem_ready held 0 → mem_error=1, halted=1 after 5 wait cycles; cycle_count frozen.
- Syscall: id_syscall=1 → DRAIN for 3 advancing cycles (one mid-drain memstall adds 1 cycle) → HALT with halted=1. Reset asserted mid-DRAIN → RUN immediately and counters=0.
